moving_avg_filter: RTL
======================

// Module: moving_avg_filter
// PURPOSE
//  Streaming N-point moving-average (boxcar) low-pass filter that drains samples from the
//  upstream sample FIFO (register file + fifo_ctrl) through its rd/empty interface.
//  Keeps its own circular window of the last N samples and a running sum.
//  Emits one averaged sample per consumed input through a 1-entry valid/ready output register.
// PARAMETERS
//  DATA_WIDTH  24  signed sample width, input and output
//  LOG2_N      3   log2 of window length; N = 2**LOG2_N, where N=8 by default
// PORTS
//  clk         in   1           system clock; the only clock
//  reset       in   1           synchronous, active-high reset
//  fifo_empty  in   1           upstream FIFO empty flag
//  fifo_rdata  in   DATA_WIDTH  upstream FIFO read data at r_addr; valid while fifo_empty=0
//  fifo_rd     out  1           pop request to upstream FIFO; combinational, high only on accept
//  out_ready   in   1           downstream can take out_data this cycle
//  out_valid   out  1           out_data holds an unconsumed average
//  out_data    out  DATA_WIDTH  signed average of the window
//  primed      out  1           window has held N real samples since reset
// BEHAVIOUR
//  - Reset, synchronous and active-high: out_valid=0, out_data=0, primed=0.
//    Window entries, acc, wr_ptr and fill_cnt all clear to 0. fifo_rd=0 while reset=1.
//  - accept = ~reset & ~fifo_empty & (~out_valid | out_ready); fifo_rd = accept.
//  - Sample x = fifo_rdata is taken in the same cycle as fifo_rd.
//  - On accept:
//    - old = window[wr_ptr]; window[wr_ptr] <= x; wr_ptr <= wr_ptr+1, wrapping mod N.
//    - acc_next = acc + x - old; acc <= acc_next.
//    - Width rule: acc is signed DATA_WIDTH+LOG2_N bits; sign-extend x and old before adding.
//    - out_data <= acc_next >>> LOG2_N (arithmetic shift, floor toward -inf); out_valid <= 1.
//  - Latency: one cycle from accept (fifo_rd high) to out_valid high with the matching average.
//  - Output handshake:
//    - Transfer occurs when out_valid & out_ready.
//    - Transfer with no accept in the same cycle: out_valid <= 0.
//    - Transfer and accept in the same cycle: out_valid stays 1 with the new data.
//      This allows one sample per cycle.
//  - Backpressure: if out_valid & ~out_ready, out_data and out_valid are held stable.
//    fifo_rd stays 0 and no sample is lost.
//  - Warm-up: entries not yet written count as 0, so early outputs are sum/N, not sum/count.
//    fill_cnt saturates at N; primed <= 1 on the accept that brings fill_cnt to N.
//    primed stays 1 until reset.
//  - fifo_empty=1: no accept; pending out_valid still drains normally.
//  - Reset mid-stream: all history is discarded and the state is identical to power-up.
//    Any unconsumed out_data is dropped.
//  - No FSM beyond the warm-up flag; the datapath is free-running on accept.
// STRUCTURE
//  - dsp_pkg (shared):
//    - DEFAULT_DATA_WIDTH=24, DEFAULT_LOG2_N=3.
//    - Function avg_shift(acc, log2n) for the arithmetic-shift divide, reused by later filters.
//  - Sub-module sample_window #(DATA_WIDTH, LOG2_N):
//    - N-entry circular delay line, synchronous reset to 0.
//    - Inputs wr_en and din. Outputs oldest (combinational window[wr_ptr]) and full (primed).
//  - Top level: accept/handshake logic, accumulator, output register.
// TESTING  (DATA_WIDTH=24, LOG2_N=3)
//  1. Reset with fifo_empty=0 -> fifo_rd=0, out_valid=0, out_data=0, primed=0 for every reset cycle.
//  2. out_ready=1, eight samples of 800 ->
//     outputs 100,200,300,400,500,600,700,800, one per cycle, each 1 cycle after its fifo_rd.
//     primed rises with the 800 output.
//  3. After test 2, eight samples of 0 -> outputs 700,600,...,0; wr_ptr wraps and primed stays 1.
//  4. Single sample -1 after reset -> out_data=-1 (floor).
//     Eight samples of 2^23-1 -> final output 8388607 with no overflow.
//     Eight samples of -8388608 -> final output -8388608.
//  5. Backpressure:
//     - out_ready=0 for 3 cycles while out_valid=1 -> fifo_rd=0 and out_data stable.
//     - Raise out_ready -> pop resumes in the same cycle and the output sequence has no gaps.
//     - fifo_empty=1 -> fifo_rd=0 and no new outputs.
//  6. Reset after five samples of 800, then one sample of 800 -> out_data=100 and primed=0.
//     This proves the history was cleared.

Source files
------------

// File: rtl/moving_avg_filter_pkg.sv
// Shared DSP constants and helpers for the moving-average filter family.
// avg_shift is kept generic (wide operand) so later filters can reuse it.
package moving_avg_filter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 24;
    localparam int DEFAULT_LOG2_N     = 3;
    localparam int AVG_MAX_WIDTH      = 64;

    // Divide by 2**log2n, rounding toward minus infinity.
    function automatic logic signed [AVG_MAX_WIDTH-1:0] avg_shift(
        input logic signed [AVG_MAX_WIDTH-1:0] acc,
        input int                              log2n
    );
        return acc >>> log2n;
    endfunction

endpackage

// File: rtl/moving_avg_filter_if.sv
// Filter bus: the upstream FIFO pop interface plus the averaged-sample output.
interface moving_avg_filter_if
    import moving_avg_filter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    // Output handshake: a sample moves downstream on every clock edge where
    // out_valid & out_ready; out_data/out_valid stay stable while out_ready is low.
    logic                         fifo_empty;
    logic signed [DATA_WIDTH-1:0] fifo_rdata;
    logic                         fifo_rd;
    logic                         out_ready;
    logic                         out_valid;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         primed;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  out_ready,
        output fifo_rd,
        output out_valid,
        output out_data,
        output primed
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output out_ready,
        input  fifo_rd,
        input  out_valid,
        input  out_data,
        input  primed
    );

endinterface

// File: rtl/moving_avg_filter_sample_window.sv
// N-entry circular delay line; presents the sample about to be overwritten.
// full rises on the write that completes the first N samples since reset.
module sample_window
    import moving_avg_filter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LOG2_N     = DEFAULT_LOG2_N
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic signed [DATA_WIDTH-1:0] oldest,
    output logic                         full
);

    localparam int N = 1 << LOG2_N;
    localparam logic [LOG2_N:0] FILL_MAX  = (LOG2_N + 1)'(N);
    localparam logic [LOG2_N:0] FILL_LAST = (LOG2_N + 1)'(N - 1);

    logic signed [DATA_WIDTH-1:0] window [N];
    logic [LOG2_N-1:0]            wr_ptr;
    logic [LOG2_N:0]              fill_cnt;

    assign oldest = window[wr_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                window[i] <= '0;
            end
            wr_ptr   <= '0;
            fill_cnt <= '0;
            full     <= 1'b0;
        end else if (wr_en) begin
            window[wr_ptr] <= din;
            wr_ptr         <= wr_ptr + 1'b1;
            if (fill_cnt != FILL_MAX) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (fill_cnt == FILL_LAST) begin
                full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/moving_avg_filter.sv
// Streaming N-point boxcar average: pops the upstream FIFO, keeps a running
// sum over the window and registers one average per accepted sample.
module moving_avg_filter
    import moving_avg_filter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LOG2_N     = DEFAULT_LOG2_N
) (
    input  logic                clk,
    input  logic                reset,
    moving_avg_filter_if.master bus
);

    localparam int ACC_WIDTH = DATA_WIDTH + LOG2_N;

    logic                         accept;
    logic                         full;
    logic signed [DATA_WIDTH-1:0] oldest;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic signed [ACC_WIDTH-1:0]  x_ext;
    logic signed [ACC_WIDTH-1:0]  old_ext;
    logic signed [DATA_WIDTH-1:0] avg_next;
    logic signed [DATA_WIDTH-1:0] out_data_r;
    logic                         out_valid_r;

    // A new sample may enter whenever the output register is empty or draining now.
    assign accept      = ~reset & ~bus.fifo_empty & (~out_valid_r | bus.out_ready);
    assign bus.fifo_rd = accept;

    // LOG2_N guard bits make the N-sample sum exact for any input values.
    assign x_ext    = {{LOG2_N{bus.fifo_rdata[DATA_WIDTH-1]}}, bus.fifo_rdata};
    assign old_ext  = {{LOG2_N{oldest[DATA_WIDTH-1]}}, oldest};
    assign acc_next = acc + x_ext - old_ext;
    assign avg_next = DATA_WIDTH'(avg_shift(AVG_MAX_WIDTH'(acc_next), LOG2_N));

    sample_window #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_N     (LOG2_N)
    ) u_window (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (accept),
        .din    (bus.fifo_rdata),
        .oldest (oldest),
        .full   (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (accept) begin
            acc         <= acc_next;
            out_data_r  <= avg_next;
            out_valid_r <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.primed    = full;

endmodule
